// File: rtl/eprisc_bus_dma.sv
// epRISC bus copy engine: requests the shared bus, reads one word, writes it back at dst, repeats per count.
// Build option EPRISC_DMA_IRQ_EN adds a sticky completion interrupt (oIrq, cleared by iIrqAck).
module eprisc_bus_dma #(
   parameter int ADDR_STEP = 1,
   parameter int READ_LAT  = 1
) (
   input  logic        iClk,
   input  logic        iRst,
   input  logic        iStart,
   input  logic [31:0] iSrc,
   input  logic [31:0] iDst,
   input  logic [15:0] iCount,
   output logic        oBusReq,
   input  logic        iBusGnt,
   output logic [31:0] oAddr,
   inout  logic [31:0] bData,
   output logic        oWrite,
   output logic        oBusy,
   output logic        oDone
`ifdef EPRISC_DMA_IRQ_EN
   ,
   output logic        oIrq,
   input  logic        iIrqAck
`endif
);

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] REQ   = 3'd1;
   localparam logic [2:0] RADDR = 3'd2;
   localparam logic [2:0] RWAIT = 3'd3;
   localparam logic [2:0] WRITE = 3'd4;
   localparam logic [2:0] DONE  = 3'd5;

   localparam logic [31:0] STEP     = 32'(ADDR_STEP);
   localparam logic [1:0]  LAT_LAST = 2'(READ_LAT - 1);

   logic [2:0]  stateReg, stateNext;
   logic [31:0] srcReg, srcNext;
   logic [31:0] dstReg, dstNext;
   logic [15:0] countReg, countNext;
   logic [1:0]  latReg, latNext;
   logic [31:0] dataReg, dataNext;

   always_comb begin
      stateNext = stateReg;
      srcNext   = srcReg;
      dstNext   = dstReg;
      countNext = countReg;
      latNext   = latReg;
      dataNext  = dataReg;
      case (stateReg)
         IDLE: begin
            if (iStart) begin
               srcNext   = iSrc;
               dstNext   = iDst;
               countNext = iCount;
               stateNext = (iCount == 16'd0) ? DONE : REQ;
            end
         end
         REQ: begin
            if (iBusGnt) begin
               stateNext = RADDR;
            end
         end
         RADDR: begin
            latNext   = 2'd0;
            stateNext = RWAIT;
         end
         RWAIT: begin
            // Responder data is only valid on the last wait cycle.
            if (latReg == LAT_LAST) begin
               dataNext  = bData;
               stateNext = WRITE;
            end else begin
               latNext = latReg + 2'd1;
            end
         end
         WRITE: begin
            srcNext   = srcReg + STEP;
            dstNext   = dstReg + STEP;
            countNext = countReg - 16'd1;
            stateNext = (countReg == 16'd1) ? DONE : REQ;
         end
         DONE: begin
            stateNext = IDLE;
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         stateReg <= IDLE;
         srcReg   <= 32'd0;
         dstReg   <= 32'd0;
         countReg <= 16'd0;
         latReg   <= 2'd0;
         dataReg  <= 32'd0;
      end else begin
         stateReg <= stateNext;
         srcReg   <= srcNext;
         dstReg   <= dstNext;
         countReg <= countNext;
         latReg   <= latNext;
         dataReg  <= dataNext;
      end
   end

   logic busState;
   logic ownBus;
   logic writing;

   // Drivers follow grant combinationally so a revoked grant frees the bus at once,
   // while the FSM still finishes the word it started.
   assign busState = (stateReg == RADDR) || (stateReg == RWAIT) || (stateReg == WRITE);
   assign ownBus   = busState && iBusGnt;
   assign writing  = ownBus && (stateReg == WRITE);

   assign oBusReq = (stateReg == REQ) || (stateReg == RADDR) || (stateReg == RWAIT);
   assign oAddr   = ownBus ? ((stateReg == WRITE) ? dstReg : srcReg) : 32'bz;
   assign oWrite  = ownBus ? (stateReg == WRITE) : 1'bz;
   assign bData   = writing ? dataReg : 32'bz;
   assign oBusy   = (stateReg != IDLE);
   assign oDone   = (stateReg == DONE);

`ifdef EPRISC_DMA_IRQ_EN
   logic irqReg, irqNext;

   always_comb begin
      irqNext = irqReg;
      if (iIrqAck) begin
         irqNext = 1'b0;
      end
      // Entering DONE sets the flag and overrides a coincident ack.
      if ((stateNext == DONE) && (stateReg != DONE)) begin
         irqNext = 1'b1;
      end
   end

   always_ff @(posedge iClk or negedge iRst) begin
      if (!iRst) begin
         irqReg <= 1'b0;
      end else begin
         irqReg <= irqNext;
      end
   end

   assign oIrq = irqReg;
`endif

endmodule

// File: tb/tb_eprisc_bus_dma.sv
// Bench for eprisc_bus_dma: ROM/RAM responder, delaying arbiter and a copy model built from the transfer rules.
// Honours EPRISC_DMA_IRQ_EN when defined.
module tb_eprisc_bus_dma;

   localparam int RL       = 2;
   localparam int WORD_CYC = RL + 3;

   logic        iClk = 1'b0;
   logic        iRst = 1'b0;
   logic        iStart = 1'b0;
   logic [31:0] iSrc = 32'd0;
   logic [31:0] iDst = 32'd0;
   logic [15:0] iCount = 16'd0;
   logic        iBusGnt = 1'b0;
   logic        oBusReq;
   logic        oBusy;
   logic        oDone;
   wire  [31:0] oAddr;
   wire         oWrite;
   wire  [31:0] bData;
`ifdef EPRISC_DMA_IRQ_EN
   logic        oIrq;
   logic        iIrqAck = 1'b0;
`endif

   // Released bus reads as address all-ones with write strobe low.
   pullup (oAddr);
   pulldown (oWrite);

   eprisc_bus_dma #(.ADDR_STEP(1), .READ_LAT(RL)) dut (
      .iClk(iClk), .iRst(iRst), .iStart(iStart), .iSrc(iSrc), .iDst(iDst), .iCount(iCount),
      .oBusReq(oBusReq), .iBusGnt(iBusGnt), .oAddr(oAddr), .bData(bData), .oWrite(oWrite),
      .oBusy(oBusy), .oDone(oDone)
`ifdef EPRISC_DMA_IRQ_EN
      , .oIrq(oIrq), .iIrqAck(iIrqAck)
`endif
   );

   initial forever #5 iClk = ~iClk;

   int total = 0;
   int bad = 0;
   int wrCount = 0;
   int reqCycles = 0;
   int doneCount = 0;
   int gntViol = 0;
   int ownCycles = 0;
   int gntDelay = 0;

   logic [31:0] rom [logic [31:0]];
   logic [31:0] ram [logic [31:0]];
   logic [31:0] pipe [0:2];

   function automatic logic [31:0] romGet(input logic [31:0] a);
      return rom.exists(a) ? rom[a] : (32'h0BAD_0000 ^ a);
   endfunction

   function automatic logic [32:0] ramGet(input logic [31:0] a);
      return ram.exists(a) ? {1'b1, ram[a]} : 33'd0;
   endfunction

   // Synchronous responder: reads appear RL cycles after the address, writes land on the strobe edge.
   assign bData = (oWrite === 1'b0) ? pipe[RL-1] : 32'bz;
   initial forever begin
      @(posedge iClk);
      if (oWrite === 1'b1) begin
         ram[oAddr] = bData;
         wrCount++;
      end
      pipe[0] <= romGet(oAddr);
      pipe[1] <= pipe[0];
      pipe[2] <= pipe[1];
   end

   // Monitor then arbiter; grant is kept through the write cycle and re-arbitrated afterwards.
   initial begin
      int  waitCnt = 0;
      bit  prevReq = 1'b0;
      bit  releasePend = 1'b0;
      bit  released;
      forever begin
         @(negedge iClk);
         released = (oAddr === 32'hFFFF_FFFF) && (oWrite === 1'b0);
         if (oBusReq === 1'b1) reqCycles++;
         if (oDone === 1'b1) doneCount++;
         if (!released) ownCycles++;
         if ((iBusGnt === 1'b0) && !released) gntViol++;
         if (gntDelay == 0) begin
            iBusGnt = 1'b1;
         end else if (releasePend) begin
            iBusGnt = 1'b0; waitCnt = 0; releasePend = 1'b0;
         end else if (oBusReq === 1'b1) begin
            if (iBusGnt == 1'b0) begin
               if (waitCnt >= gntDelay) iBusGnt = 1'b1;
               else waitCnt++;
            end
         end else if ((iBusGnt == 1'b1) && prevReq) begin
            releasePend = 1'b1;
         end else begin
            iBusGnt = 1'b0; waitCnt = 0;
         end
         prevReq = (oBusReq === 1'b1);
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic fillRom(input logic [31:0] s, input int c);
      for (int i = 0; i < c; i++) rom[s + 32'(i)] = $urandom;
   endtask

   // Start a copy, optionally poke iStart at cycle pokeAt, and compare against the copy model.
   task automatic runCopy(input string tag, input logic [31:0] s, input logic [31:0] d,
                          input logic [15:0] c, input bit timed, input int pokeAt);
      int cyc;
      bit seen;
      int w0;
      w0 = wrCount; seen = 1'b0; cyc = 0;
      iSrc = s; iDst = d; iCount = c; iStart = 1'b1;
      while (!seen && cyc < 5000) begin
         @(negedge iClk);
         cyc++;
         iStart = 1'b0;
         if (cyc == 1) check($sformatf("%s_busy", tag), oBusy, 1);
         if (cyc == pokeAt) begin
            iStart = 1'b1; iSrc = ~s; iDst = ~d; iCount = 16'd7;
         end
         if (oDone === 1'b1) seen = 1'b1;
      end
      check($sformatf("%s_done_seen", tag), seen, 1);
      if (timed) check($sformatf("%s_cycles", tag), cyc, int'(c) * WORD_CYC + 1);
      check($sformatf("%s_writes", tag), wrCount - w0, int'(c));
      for (int i = 0; i < int'(c); i++)
         check($sformatf("%s_word%0d", tag, i), ramGet(d + 32'(i)), {1'b1, romGet(s + 32'(i))});
      @(negedge iClk);
      iStart = 1'b0;
      check($sformatf("%s_idle_busy", tag), oBusy, 0);
      check($sformatf("%s_idle_done", tag), oDone, 0);
      @(negedge iClk);
      check($sformatf("%s_idle_busy2", tag), oBusy, 0);
      check($sformatf("%s_idle_req", tag), oBusReq, 0);
      $display("copy %s src=%h dst=%h count=%0d cycles=%0d", tag, s, d, c, cyc);
   endtask

   initial begin
      logic [31:0] s;
      logic [31:0] d;
      logic [15:0] c;
      int r0;
      int o0;
      int v0;
      int w0;
      int d0;
      int cyc;
      bit seen;

      repeat (3) @(negedge iClk);
      check("rst_busy", oBusy, 0);
      check("rst_req", oBusReq, 0);
      check("rst_done", oDone, 0);
      check("rst_addr_z", oAddr, 32'hFFFF_FFFF);
      check("rst_write_z", oWrite, 0);
`ifdef EPRISC_DMA_IRQ_EN
      check("rst_irq", oIrq, 0);
`endif
      iRst = 1'b1;
      @(negedge iClk);

      // Copy 3 with fixed ROM image, start pulsed again while busy.
      rom[32'h0] = 32'h2100_0009; rom[32'h1] = 32'h2300_000D; rom[32'h2] = 32'h0831_0000;
      runCopy("copy3", 32'h0, 32'h100, 16'd3, 1'b1, 4);

      // Zero count: no bus activity, start repeated on the DONE cycle.
      r0 = reqCycles; o0 = ownCycles;
      runCopy("zero", 32'h40, 32'h140, 16'd0, 1'b1, 1);
      check("zero_no_req", reqCycles - r0, 0);
      check("zero_no_drive", ownCycles - o0, 0);

      // Withheld grant.
      gntDelay = 10; r0 = reqCycles; v0 = gntViol;
      s = 32'h0000_2000; d = 32'h0000_3000;
      fillRom(s, 3);
      runCopy("gnt_wait", s, d, 16'd3, 1'b0, 0);
      check("gnt_wait_req_held", (reqCycles - r0) >= 3 * (10 + 1), 1);
      check("gnt_wait_no_drive", gntViol - v0, 0);
      gntDelay = 0;
      @(negedge iClk);

      // Address wrap on both source and destination.
      s = 32'hFFFF_FFFF; d = 32'hFFFF_FFFE;
      fillRom(s, 3);
      runCopy("wrap", s, d, 16'd3, 1'b1, 0);

      // Reset during the wait of word 2 of 4.
      s = 32'h0000_5000; d = 32'h0000_6000;
      fillRom(s, 4);
      w0 = wrCount; d0 = doneCount;
      iSrc = s; iDst = d; iCount = 16'd4; iStart = 1'b1;
      @(negedge iClk);
      iStart = 1'b0;
      repeat (WORD_CYC + 2) @(negedge iClk);
      check("rst_mid_addr", oAddr, s + 32'd1);
      check("rst_mid_req", oBusReq, 1);
      #2 iRst = 1'b0;
      #1;
      check("rst_mid_addr_z", oAddr, 32'hFFFF_FFFF);
      check("rst_mid_write_z", oWrite, 0);
      check("rst_mid_busy", oBusy, 0);
      check("rst_mid_req0", oBusReq, 0);
      check("rst_mid_writes", wrCount - w0, 1);
      repeat (3) @(negedge iClk);
      check("rst_mid_no_done", doneCount - d0, 0);
      iRst = 1'b1;
      @(negedge iClk);
      runCopy("restart", s, d, 16'd4, 1'b1, 0);

      // Randomized copies with random arbiter delay.
      for (int t = 0; t < 5; t++) begin
         s = $urandom;
         d = s ^ 32'h8000_0000;
         c = 16'($urandom_range(1, 6));
         gntDelay = $urandom_range(0, 3);
         fillRom(s, int'(c));
         @(negedge iClk);
         runCopy($sformatf("rand%0d", t), s, d, c, gntDelay == 0, $urandom_range(2, 6));
      end
      gntDelay = 0;
      @(negedge iClk);

`ifdef EPRISC_DMA_IRQ_EN
      s = 32'h0000_7000; d = 32'h0000_7800;
      fillRom(s, 1);
      iSrc = s; iDst = d; iCount = 16'd1; iStart = 1'b1;
      seen = 1'b0; cyc = 0;
      while (!seen && cyc < 200) begin
         @(negedge iClk);
         cyc++;
         iStart = 1'b0;
         if (oDone === 1'b1) seen = 1'b1;
      end
      check("irq_done_seen", seen, 1);
      check("irq_with_done", oIrq, 1);
      repeat (5) @(negedge iClk);
      check("irq_held", oIrq, 1);
      iIrqAck = 1'b1;
      @(negedge iClk);
      iIrqAck = 1'b0;
      check("irq_cleared", oIrq, 0);
      $display("copy irq src=%h dst=%h count=1 cycles=%0d", s, d, cyc);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
